// File: rtl/expr_pkg.sv
// Shared token codes, ASCII constants and sizing defaults for the expression
// emitter and any downstream expression checker.
package expr_pkg;

  typedef enum logic [2:0] {
    TOK_DIGIT = 3'd0,
    TOK_PLUS  = 3'd1,
    TOK_MUL   = 3'd2,
    TOK_LPAR  = 3'd3,
    TOK_RPAR  = 3'd4,
    TOK_END   = 3'd5
  } tok_e;

  typedef enum logic [1:0] {
    ST_OPND,
    ST_OPR,
    ST_CLOSE,
    ST_ERR
  } state_e;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_PLUS = 8'h2B;
  localparam logic [7:0] ASCII_MUL  = 8'h2A;
  localparam logic [7:0] ASCII_LPAR = 8'h28;
  localparam logic [7:0] ASCII_RPAR = 8'h29;

  localparam int unsigned DEFAULT_MAX_DEPTH = 7;

endpackage

// File: rtl/expr_emitter_if.sv
// Token-in / character-out bundle of the expression emitter.
interface expr_emitter_if;
  logic       tok_valid;
  logic [2:0] tok_type;
  logic [3:0] tok_digit;
  logic       tok_ready;
  logic [7:0] out;
  logic       out_valid;
  logic       done;
  logic       err;

  modport master (
    output tok_valid, tok_type, tok_digit,
    input  tok_ready, out, out_valid, done, err
  );

  modport slave (
    input  tok_valid, tok_type, tok_digit,
    output tok_ready, out, out_valid, done, err
  );
endinterface

// File: rtl/expr_ascii_enc.sv
// Combinational token/digit to ASCII character map; non-printing codes give 0.
module expr_ascii_enc
  import expr_pkg::*;
(
  input  tok_e       tok_type_i,
  input  logic [3:0] digit_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    ascii_o = '0;
    case (tok_type_i)
      TOK_DIGIT: ascii_o = ASCII_ZERO + {4'h0, digit_i};
      TOK_PLUS:  ascii_o = ASCII_PLUS;
      TOK_MUL:   ascii_o = ASCII_MUL;
      TOK_LPAR:  ascii_o = ASCII_LPAR;
      TOK_RPAR:  ascii_o = ASCII_RPAR;
      default:   ascii_o = '0;
    endcase
  end

endmodule

// File: rtl/expr_emitter.sv
// Grammar-checking token-to-ASCII emitter; auto-closes open parentheses on END
// and latches a sticky error on any token the grammar does not allow.
module expr_emitter
  import expr_pkg::*;
#(
  parameter int unsigned MAX_DEPTH = DEFAULT_MAX_DEPTH
) (
  input logic           clk,
  input logic           clr,
  expr_emitter_if.slave bus
);

  localparam int unsigned    DW        = $clog2(MAX_DEPTH + 1);
  localparam logic [DW-1:0]  DEPTH_MAX = DW'(MAX_DEPTH);
  localparam logic [DW-1:0]  DEPTH_ONE = DW'(1);

  state_e        state_q, state_d;
  logic [DW-1:0] depth_q, depth_d;
  logic [7:0]    out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          accept, bad;
  tok_e          tok, enc_type;
  logic [7:0]    enc_ascii;

  assign tok           = tok_e'(bus.tok_type);
  assign bus.tok_ready = (state_q != ST_CLOSE);
  assign accept        = bus.tok_valid & bus.tok_ready;
  // During auto-close the encoder is fed RPAR regardless of the idle token bus
  assign enc_type      = (state_q == ST_CLOSE) ? TOK_RPAR : tok;

  expr_ascii_enc u_enc (
    .tok_type_i (enc_type),
    .digit_i    (bus.tok_digit),
    .ascii_o    (enc_ascii)
  );

  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;
    bad         = 1'b0;
    case (state_q)
      ST_OPND: if (accept) begin
        if (tok == TOK_DIGIT && bus.tok_digit <= 4'd9) begin
          out_valid_d = 1'b1;
          state_d     = ST_OPR;
        end else if (tok == TOK_LPAR && depth_q < DEPTH_MAX) begin
          out_valid_d = 1'b1;
          depth_d     = depth_q + 1'b1;
        end else begin
          bad = 1'b1;
        end
      end
      ST_OPR: if (accept) begin
        case (tok)
          TOK_PLUS, TOK_MUL: begin
            out_valid_d = 1'b1;
            state_d     = ST_OPND;
          end
          TOK_RPAR: begin
            if (depth_q != '0) begin
              out_valid_d = 1'b1;
              depth_d     = depth_q - 1'b1;
            end else begin
              bad = 1'b1;
            end
          end
          TOK_END: begin
            if (depth_q == '0) begin
              done_d  = 1'b1;
              state_d = ST_OPND;
            end else begin
              state_d = ST_CLOSE;
            end
          end
          default: bad = 1'b1;
        endcase
      end
      ST_CLOSE: begin
        out_valid_d = 1'b1;
        depth_d     = depth_q - 1'b1;
        if (depth_q == DEPTH_ONE) begin
          done_d  = 1'b1;
          state_d = ST_OPND;
        end
      end
      default: err_d = 1'b1;
    endcase
    if (bad) begin
      state_d = ST_ERR;
      err_d   = 1'b1;
    end
    out_d = out_valid_d ? enc_ascii : '0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= ST_OPND;
      depth_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: doc/expr_emitter.md
EXPR_EMITTER -- requirements
Module: expr_emitter

Interface
REQ-001 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide port: clr  input  1  reset, synchronous, active-high.
REQ-003 SHALL provide port: tok_valid  input  1  token offered this cycle.
REQ-004 SHALL provide port: tok_type  input  3  token code: DIGIT=0, PLUS=1, MUL=2, LPAR=3, RPAR=4, END=5; codes 6-7 illegal.
REQ-005 SHALL provide port: tok_digit  input  4  digit value for DIGIT, 0-9 legal, ignored for other types.
REQ-006 SHALL provide port: tok_ready  output  1  block accepts token this cycle; a transfer occurs when tok_valid&tok_ready at a rising edge.
REQ-007 SHALL provide port: out  output  8  ASCII character emitted ('0'-'9', '+', '*', '(', ')').
REQ-008 SHALL provide port: out_valid  output  1  out holds a new character this cycle.
REQ-009 SHALL provide port: done  output  1  one-cycle pulse after final character of a complete expression.
REQ-010 SHALL provide port: err  output  1  sticky grammar/overflow error flag.
REQ-011 SHALL define parameter MAX_DEPTH, default 7, meaning maximum open-parenthesis nesting.

Function
REQ-012 SHALL implement FSM states OPND (expect operand), OPR (expect operator), CLOSE (auto-closing), ERR.
REQ-013 SHALL register out/out_valid: a character for a token accepted at edge N is visible in the cycle after edge N (latency 1), one character per cycle max.
REQ-014 SHALL drive out=8'h00 and out_valid=0 in any cycle with no emitted character.
REQ-015 In OPND: DIGIT (0-9) -> emit ASCII '0'+digit, go OPR; LPAR with depth<MAX_DEPTH -> emit '(', depth+1, stay OPND.
REQ-016 In OPR: PLUS -> emit '+', go OPND; MUL -> emit '*', go OPND; RPAR with depth>0 -> emit ')', depth-1, stay OPR; END with depth=0 -> done pulse next cycle, go OPND; END with depth>0 -> go CLOSE.
REQ-017 In CLOSE: emit ')' every cycle, decrement depth; when depth reaches 0 pulse done in the same cycle as the last ')' and go OPND.
REQ-018 SHALL hold tok_ready=0 in CLOSE and tok_ready=1 in OPND, OPR, ERR.
REQ-019 Any other accepted token (illegal code, digit>9, wrong type for state, RPAR at depth 0, LPAR at depth MAX_DEPTH, END in OPND) SHALL emit nothing, set err=1 next cycle, go ERR.
REQ-020 In ERR: accept and discard all tokens, emit nothing, err stays 1 until clr.
REQ-021 depth SHALL be a $clog2(MAX_DEPTH+1)-bit counter that never wraps (overflow/underflow are errors per REQ-019).
REQ-022 tok_valid=0 SHALL leave state and depth unchanged.
REQ-023 Emitted stream between consecutive done pulses SHALL always be a well-formed expression over digits, '+', '*', balanced parentheses.

Reset
REQ-024 clr=1 at a rising edge SHALL set state=OPND, depth=0, out=8'h00, out_valid=0, done=0, err=0, discarding any token offered that cycle.
REQ-025 clr SHALL take priority over all events, including mid-CLOSE and mid-token; no partial expression continues after clr.
REQ-026 tok_ready SHALL be 1 in the cycle after clr deasserts.

Structure
REQ-027 SHALL place token codes, ASCII constants ('0', '+', '*', '(', ')') and default MAX_DEPTH in shared package expr_pkg, reusable by the expression checker.
REQ-028 SHALL use one sub-module expr_ascii_enc (combinational token/digit -> ASCII); FSM and depth counter remain in expr_emitter.

Verification
REQ-029 Tokens LPAR,DIGIT1,PLUS,DIGIT2,RPAR,MUL,DIGIT3,END -> out "(1+2)*3" on consecutive cycles, done=1 one cycle after '3', err=0.
REQ-030 Tokens LPAR,LPAR,DIGIT4,END -> "((4" then "))" with tok_ready=0 for 2 cycles, done coincident with second ')'.
REQ-031 Tokens DIGIT1,DIGIT2 -> '1' emitted, second digit discarded, err=1, all later tokens produce no output until clr.
REQ-032 Eight LPAR tokens with MAX_DEPTH=7 -> seven '(' emitted, eighth sets err=1; RPAR as first token -> err=1, no output.
REQ-033 clr pulsed during CLOSE after "(((5" -> output stops, out=8'h00, err=0, depth=0; then DIGIT9,END -> "9", done.
REQ-034 tok_valid toggled 0/1 between tokens of "1+(9)" -> same character sequence with gaps, no duplicates, done once.
